and_reduce_sched: RTL and testbench

AND_REDUCE_SCHED -- requirements
Module: and_reduce_sched

---
 rtl/and_reduce_sched.sv | 126 ++++++++++++
 tb/tb_and_reduce_sched.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/and_reduce_sched.sv
// Round-robin scheduler that time-shares one WIDTH-bit AND lane across R requesters,
// reducing each accepted N-word operand to a single word, one word per cycle.
module and_reduce_sched #(
  parameter int N         = 4,
  parameter int WIDTH     = 8,
  parameter int R         = 4,
  parameter int EARLY_OUT = 1,
  localparam int IDW      = (R > 1) ? $clog2(R) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [R-1:0]           req_valid,
  input  logic [R*N*WIDTH-1:0]   req_data,
  output logic [R-1:0]           req_ready,
  output logic                   rsp_valid,
  output logic [WIDTH-1:0]       rsp_data,
  output logic [IDW-1:0]         rsp_id,
  input  logic                   rsp_ready,
  output logic                   busy
);

  localparam int CW  = $clog2(N + 1);
  localparam int OPW = N * WIDTH;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] REDUCE  = 2'd1;
  localparam logic [1:0] RESPOND = 2'd2;

  logic [1:0]       state;
  logic [IDW-1:0]   rr_ptr;
  logic [IDW-1:0]   id;
  logic [WIDTH-1:0] acc;
  logic [CW-1:0]    cnt;
  logic [OPW-1:0]   operand;

  logic [R-1:0]     valid_rot;
  logic [IDW:0]     grant_off;
  logic [IDW:0]     grant_sum;
  logic [IDW-1:0]   grant_idx;
  logic             grant_found;
  logic [OPW-1:0]   sel_op;
  logic [WIDTH-1:0] cur_word;
  logic [WIDTH-1:0] next_acc;
  logic             last_word;

  // Rotate the request vector so bit 0 is rr_ptr; the lowest set bit is the winner.
  always_comb begin
    valid_rot   = R'({req_valid, req_valid} >> rr_ptr);
    grant_found = |req_valid;
    grant_off   = '0;
    for (int i = R - 1; i >= 0; i--) begin
      if (valid_rot[i]) grant_off = (IDW + 1)'(i);
    end
    grant_sum = {1'b0, rr_ptr} + grant_off;
    if (grant_sum >= (IDW + 1)'(R)) grant_sum = grant_sum - (IDW + 1)'(R);
    grant_idx = grant_sum[IDW-1:0];
  end

  always_comb begin
    req_ready = '0;
    if (!rst && state == IDLE && grant_found)
      req_ready = {{(R - 1){1'b0}}, 1'b1} << grant_idx;
  end

  always_comb begin
    sel_op = '0;
    for (int r = 0; r < R; r++) begin
      if (grant_idx == IDW'(r)) sel_op = req_data[r*OPW +: OPW];
    end
  end

  always_comb begin
    cur_word = '0;
    for (int k = 0; k < N; k++) begin
      if (cnt == CW'(k)) cur_word = operand[k*WIDTH +: WIDTH];
    end
    next_acc  = acc & cur_word;
    last_word = (cnt == CW'(N - 1));
  end

  // Early exit looks at the value being produced this cycle, so a zero
  // accumulator leaves REDUCE on the same edge that makes it zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      rr_ptr  <= '0;
      id      <= '0;
      acc     <= '0;
      cnt     <= '0;
      operand <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_found) begin
            operand <= sel_op;
            acc     <= sel_op[WIDTH-1:0];
            cnt     <= CW'(1);
            id      <= grant_idx;
            state   <= (N > 1) ? REDUCE : RESPOND;
          end
        end
        REDUCE: begin
          acc <= next_acc;
          cnt <= cnt + CW'(1);
          if (last_word || (EARLY_OUT != 0 && next_acc == '0))
            state <= RESPOND;
        end
        RESPOND: begin
          if (rsp_ready) begin
            rr_ptr <= (id == IDW'(R - 1)) ? '0 : id + IDW'(1);
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    rsp_valid = (state == RESPOND);
    rsp_data  = rsp_valid ? acc : '0;
    rsp_id    = rsp_valid ? id : '0;
    busy      = (state != IDLE);
  end

endmodule

// File: tb/tb_and_reduce_sched.sv
// Scoreboard bench for and_reduce_sched: stimulus pushes expected results,
// a negedge monitor pops and compares every accepted response.
module tb_and_reduce_sched;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req_valid;
  logic [127:0] req_data;
  logic [3:0]   req_ready;
  logic         rsp_valid;
  logic [7:0]   rsp_data;
  logic [1:0]   rsp_id;
  logic         rsp_ready;
  logic         busy;

  logic [1:0]   v1;
  logic [15:0]  d1;
  logic [1:0]   req_ready1;
  logic         rsp_valid1;
  logic [7:0]   rsp_data1;
  logic [0:0]   rsp_id1;
  logic         rsp_ready1;
  logic         busy1;

  typedef struct {
    logic [7:0] data;
    logic [1:0] id;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  and_reduce_sched #(.N(4), .WIDTH(8), .R(4), .EARLY_OUT(1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rsp_id(rsp_id), .rsp_ready(rsp_ready), .busy(busy)
  );

  and_reduce_sched #(.N(1), .WIDTH(8), .R(2), .EARLY_OUT(1)) dut1 (
    .clk(clk), .rst(rst), .req_valid(v1), .req_data(d1),
    .req_ready(req_ready1), .rsp_valid(rsp_valid1), .rsp_data(rsp_data1),
    .rsp_id(rsp_id1), .rsp_ready(rsp_ready1), .busy(busy1)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Raise one request, confirm the same-cycle grant, drop it after the accept edge.
  task automatic applyStimulus(input int r, input logic [31:0] words, input logic [7:0] exp_data,
                               input bit push_exp);
    exp_t e;
    tick();
    req_data[r*32 +: 32] = words;
    req_valid[r] = 1'b1;
    if (push_exp) begin
      e.data = exp_data;
      e.id   = 2'(r);
      sb.push_back(e);
    end
    @(negedge clk);
    checkOutput("req_ready_grant", 32'(req_ready), 32'(4'b0001 << r));
    @(posedge clk);
    #2;
    req_valid[r] = 1'b0;
  endtask

  task automatic measure(output int lat, output int bc);
    lat = 0;
    bc  = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (busy) bc++;
      if (rsp_valid && lat == 0) lat = k;
      if (!busy) break;
    end
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (!busy) break;
    end
    checkOutput("idle_reached", 32'(busy), 32'd0);
  endtask

  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_rsp actual=id%0d/data%0h required=none at %0t",
                 rsp_id, rsp_data, $time);
      end else begin
        mon_e = sb.pop_front();
        checkOutput("rsp_data", 32'(rsp_data), 32'(mon_e.data));
        checkOutput("rsp_id", 32'(rsp_id), 32'(mon_e.id));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat, bc, seen;
    bit found;
    int   rr_order [5] = '{0, 1, 2, 3, 0};
    logic [7:0] rr_res [4] = '{8'h81, 8'h0F, 8'hAA, 8'hF0};
    exp_t e;

    rst = 1'b1; req_valid = 4'hF; req_data = '0; rsp_ready = 1'b1;
    v1 = 2'b11; d1 = '0; rsp_ready1 = 1'b1;

    // Reset: outputs quiet and req_ready gated even with every request raised.
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_rsp_valid", 32'(rsp_valid), 0);
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_req_ready", 32'(req_ready), 0);
    checkOutput("rst_rsp_data", 32'(rsp_data), 0);
    checkOutput("rst_rsp_id", 32'(rsp_id), 0);
    checkOutput("rst_req_ready1", 32'(req_ready1), 0);
    tick();
    rst = 1'b0; req_valid = '0; v1 = '0;
    @(negedge clk);
    checkOutput("post_rst_rsp_valid", 32'(rsp_valid), 0);
    checkOutput("post_rst_busy", 32'(busy), 0);

    // Single request: FF & F0 & 3C & FC = 30, latency 4, busy 4 cycles.
    applyStimulus(2, 32'hFC3C_F0FF, 8'h30, 1'b1);
    measure(lat, bc);
    checkOutput("single_latency", 32'(lat), 4);
    checkOutput("single_busy_cycles", 32'(bc), 4);

    // Round robin from a fresh reset with all four requesters held high.
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req_data = {32'hF0F8_FCFE, 32'hAAFF_EEFF, 32'h0F1F_3F7F, 32'hFFFF_FF81};
    req_valid = 4'hF;
    for (int g = 0; g < 5; g++) begin
      found = 1'b0;
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        if (req_ready != 0) begin
          found = 1'b1;
          break;
        end
      end
      checkOutput("rr_grant_seen", 32'(found), 1);
      checkOutput("rr_grant", 32'(req_ready), 32'(4'b0001 << rr_order[g]));
      e.data = rr_res[rr_order[g]];
      e.id   = 2'(rr_order[g]);
      sb.push_back(e);
      @(posedge clk);
    end
    #2;
    req_valid = '0;
    wait_idle();

    // Early out: 0F & F0 = 00 ends the reduction after two cycles.
    applyStimulus(1, 32'hFFFF_F00F, 8'h00, 1'b1);
    measure(lat, bc);
    checkOutput("early_latency", 32'(lat), 2);

    // Consumer stall: response held stable, a waiting request is not dropped.
    tick();
    rsp_ready = 1'b0;
    applyStimulus(0, 32'hFFFF_FFFF, 8'hFF, 1'b1);
    found = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (rsp_valid) begin
        found = 1'b1;
        break;
      end
    end
    checkOutput("stall_rsp_seen", 32'(found), 1);
    tick();
    req_data[3*32 +: 32] = 32'h80C0_E0F0;
    req_valid[3] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checkOutput("stall_rsp_valid", 32'(rsp_valid), 1);
      checkOutput("stall_rsp_data", 32'(rsp_data), 32'hFF);
      checkOutput("stall_rsp_id", 32'(rsp_id), 0);
      checkOutput("stall_req_ready", 32'(req_ready), 0);
    end
    tick();
    rsp_ready = 1'b1;
    e.data = 8'h80;
    e.id   = 2'd3;
    sb.push_back(e);
    @(negedge clk);
    @(negedge clk);
    checkOutput("stall_release_valid", 32'(rsp_valid), 0);
    checkOutput("held_req_granted", 32'(req_ready), 32'b1000);
    @(posedge clk);
    #2;
    req_valid[3] = 1'b0;
    wait_idle();

    // Reset while reducing: operation dropped, next request served correctly.
    applyStimulus(1, 32'hFFFF_FFFF, 8'hFF, 1'b0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    checkOutput("abort_busy", 32'(busy), 0);
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    checkOutput("abort_no_rsp", 32'(seen), 0);
    applyStimulus(3, 32'h1234_5678, 8'h10, 1'b1);
    measure(lat, bc);
    checkOutput("after_abort_latency", 32'(lat), 4);

    // Single-word configuration answers one cycle after accept.
    tick();
    d1 = 16'h3C5A;
    v1 = 2'b10;
    @(negedge clk);
    checkOutput("n1_req_ready", 32'(req_ready1), 32'b10);
    @(posedge clk);
    #2;
    v1 = 2'b00;
    @(negedge clk);
    checkOutput("n1_rsp_valid", 32'(rsp_valid1), 1);
    checkOutput("n1_rsp_data", 32'(rsp_data1), 32'h3C);
    checkOutput("n1_rsp_id", 32'(rsp_id1), 1);
    @(negedge clk);
    checkOutput("n1_rsp_done", 32'(rsp_valid1), 0);

    wait_idle();
    checkOutput("scoreboard_drained", 32'(sb.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
